// File: rtl/mealy_det_pkg.sv
// Shared defaults and helpers for the Mealy serial pattern detector.
//   PAT_LEN_DEF     default pattern length in bits
//   CNT_W_DEF       default match counter width
//   DEFAULT_PAT_DEF default pattern after reset (MSB = oldest bit)
//   fill_w()        width needed to hold a fill count of 0..PAT_LEN
package mealy_det_pkg;

  localparam int unsigned PAT_LEN_DEF = 4;
  localparam int unsigned CNT_W_DEF = 8;
  localparam logic [3:0] DEFAULT_PAT_DEF = 4'b1011;

  function automatic int unsigned fill_w(input int unsigned pat_len);
    return $clog2(pat_len + 1);
  endfunction

endpackage

// File: rtl/mealy_pattern_detector_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   CLK  in   clock, posedge
//   RST  in   synchronous active-high reset, clears the count
//   clr  in   synchronous clear (lower priority than RST)
//   inc  in   increment request, ignored once saturated
//   cnt  out  W-bit count
//   sat  out  high while cnt is all-ones
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);

  logic [W-1:0] cnt_q, cnt_d;

  assign sat = (cnt_q == {W{1'b1}});
  assign cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !sat) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mealy_pattern_detector.sv
// Mealy serial pattern detector with run-time loadable pattern and overlap mode.
// y rises combinationally in the same cycle the final pattern bit is presented.
// Ports:
//   CLK          in   clock, posedge
//   RST          in   synchronous active-high reset
//   x            in   serial data bit
//   x_valid      in   x is sampled this cycle
//   cfg_load     in   load cfg_pattern/cfg_overlap, drops this cycle's bit
//   cfg_pattern  in   new pattern, MSB = first bit received
//   cfg_overlap  in   1 = overlapping matches allowed
//   y            out  match strobe (combinational)
//   match_cnt    out  saturating count of matches since reset/load
//   cnt_sat      out  match_cnt is all-ones
module mealy_pattern_detector
  import mealy_det_pkg::*;
#(
  parameter int unsigned PAT_LEN = PAT_LEN_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter logic [PAT_LEN-1:0] DEFAULT_PAT = PAT_LEN'(DEFAULT_PAT_DEF)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               x,
  input  logic               x_valid,
  input  logic               cfg_load,
  input  logic [PAT_LEN-1:0] cfg_pattern,
  input  logic               cfg_overlap,
  output logic               y,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat
);

  localparam int unsigned FillW = fill_w(PAT_LEN);

  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic [FillW-1:0]   fill_q, fill_d;
  logic               ovl_q, ovl_d;
  logic [PAT_LEN-1:0] window;
  logic               accept;
  logic               fill_ready;

  assign window = {hist_q[PAT_LEN-2:0], x};
  assign accept = x_valid & ~cfg_load;
  // With fewer than PAT_LEN-1 real bits, window still holds reset zeros;
  // gating on fill stops those zeros matching a zero-heavy pattern.
  assign fill_ready = (fill_q >= FillW'(PAT_LEN - 1));
  assign y = accept & ~RST & fill_ready & (window == pat_q);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    ovl_d  = ovl_q;
    if (cfg_load) begin
      pat_d  = cfg_pattern;
      ovl_d  = cfg_overlap;
      hist_d = '0;
      fill_d = '0;
    end else if (accept) begin
      if (y && !ovl_q) begin
        // Non-overlap: the matched bits are consumed, start over from empty.
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = window;
        if (fill_q != FillW'(PAT_LEN)) begin
          fill_d = fill_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= DEFAULT_PAT;
      ovl_q  <= 1'b1;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      ovl_q  <= ovl_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .CLK(CLK),
    .RST(RST),
    .clr(cfg_load),
    .inc(y),
    .cnt(match_cnt),
    .sat(cnt_sat)
  );

endmodule

// File: tb/tb_mealy_pattern_detector.sv
// Bench for mealy_pattern_detector: two instances (CNT_W=8 and CNT_W=2) share one
// directed stimulus stream. A queue-based model is checked on every negedge, and
// hand-computed literals pin the expected y and counter values at key points.
module tb_mealy_pattern_detector;

  logic       CLK;
  logic       RST;
  logic       x;
  logic       x_valid;
  logic       cfg_load;
  logic [3:0] cfg_pattern;
  logic       cfg_overlap;
  logic       y_a, y_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic       sat_a, sat_b;

  int errors = 0;
  int checks = 0;

  mealy_pattern_detector #(
    .PAT_LEN(4),
    .CNT_W(8),
    .DEFAULT_PAT(4'b1011)
  ) dut_a (
    .CLK(CLK),
    .RST(RST),
    .x(x),
    .x_valid(x_valid),
    .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_overlap(cfg_overlap),
    .y(y_a),
    .match_cnt(cnt_a),
    .cnt_sat(sat_a)
  );

  mealy_pattern_detector #(
    .PAT_LEN(4),
    .CNT_W(2),
    .DEFAULT_PAT(4'b1011)
  ) dut_b (
    .CLK(CLK),
    .RST(RST),
    .x(x),
    .x_valid(x_valid),
    .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_overlap(cfg_overlap),
    .y(y_b),
    .match_cnt(cnt_b),
    .cnt_sat(sat_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the accepted bits since the last clear, newest at the back.
  bit          mq[$];
  int unsigned m_matches = 0;
  logic [3:0]  m_pat = 4'b1011;
  bit          m_ovl = 1'b1;

  always @(negedge CLK) begin
    logic [3:0]  w;
    logic        exp_y;
    int unsigned ea, eb;
    exp_y = 1'b0;
    if (!RST && x_valid && !cfg_load && mq.size() >= 3) begin
      w = {mq[mq.size()-3], mq[mq.size()-2], mq[mq.size()-1], x};
      exp_y = (w == m_pat);
    end
    ea = (m_matches > 255) ? 255 : m_matches;
    eb = (m_matches > 3) ? 3 : m_matches;
    check("model_y_a", {31'b0, y_a}, {31'b0, exp_y});
    check("model_y_b", {31'b0, y_b}, {31'b0, exp_y});
    check("model_cnt_a", {24'b0, cnt_a}, ea);
    check("model_cnt_b", {30'b0, cnt_b}, eb);
    check("model_sat_a", {31'b0, sat_a}, {31'b0, ea == 255});
    check("model_sat_b", {31'b0, sat_b}, {31'b0, eb == 3});
    // State as it will be after the coming posedge.
    if (RST) begin
      mq.delete();
      m_matches = 0;
      m_pat = 4'b1011;
      m_ovl = 1'b1;
    end else if (cfg_load) begin
      mq.delete();
      m_matches = 0;
      m_pat = cfg_pattern;
      m_ovl = cfg_overlap;
    end else if (x_valid) begin
      if (exp_y) m_matches++;
      if (exp_y && !m_ovl) begin
        mq.delete();
      end else begin
        mq.push_back(x);
        if (mq.size() > 4) void'(mq.pop_front());
      end
    end
  end

  task automatic send(input logic b, input logic exp_y, input string name);
    @(posedge CLK);
    #1;
    x = b;
    x_valid = 1'b1;
    cfg_load = 1'b0;
    @(negedge CLK);
    check(name, {31'b0, y_a}, {31'b0, exp_y});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      x_valid = 1'b0;
      cfg_load = 1'b0;
      x = 1'b0;
    end
  endtask

  task automatic load(input logic [3:0] p, input logic ovl);
    @(posedge CLK);
    #1;
    cfg_load = 1'b1;
    cfg_pattern = p;
    cfg_overlap = ovl;
    x_valid = 1'b0;
  endtask

  task automatic send_stream(input logic [15:0] bits, input logic [15:0] exp, input int n,
                             input string name);
    for (int i = n - 1; i >= 0; i--) send(bits[i], exp[i], name);
  endtask

  initial begin
    RST = 1'b1;
    x = 1'b0;
    x_valid = 1'b0;
    cfg_load = 1'b0;
    cfg_pattern = 4'b0000;
    cfg_overlap = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check("reset_y", {31'b0, y_a}, 32'd0);
    check("reset_cnt", {24'b0, cnt_a}, 32'd0);
    check("reset_sat", {31'b0, sat_a}, 32'd0);

    // 1: overlapping, stream 1011011 -> y on bits 4 and 7
    send_stream(16'b1011011, 16'b0001001, 7, "t1_y");
    idle(1);
    @(negedge CLK);
    check("t1_cnt", {24'b0, cnt_a}, 32'd2);

    // 2: non-overlapping -> only bit 4 matches
    load(4'b1011, 1'b0);
    send_stream(16'b1011011, 16'b0001000, 7, "t2_y");
    idle(1);
    @(negedge CLK);
    check("t2_cnt", {24'b0, cnt_a}, 32'd1);

    // 3: all-zero pattern with valid gaps
    load(4'b0000, 1'b1);
    send(1'b0, 1'b0, "t3_y1");
    idle(2);
    send(1'b0, 1'b0, "t3_y2");
    idle(1);
    send(1'b0, 1'b0, "t3_y3");
    send(1'b0, 1'b1, "t3_y4");
    idle(1);
    @(negedge CLK);
    check("t3_cnt", {24'b0, cnt_a}, 32'd1);

    // 4: saturation on the 2-bit counter
    load(4'b1011, 1'b1);
    send_stream(16'b1011011011, 16'b0001001001, 10, "t4_y");
    idle(1);
    @(negedge CLK);
    check("t4_cnt_b_3rd", {30'b0, cnt_b}, 32'd3);
    check("t4_sat_b_3rd", {31'b0, sat_b}, 32'd1);
    send_stream(16'b011, 16'b001, 3, "t4_y");
    idle(1);
    @(negedge CLK);
    check("t4_cnt_b_end", {30'b0, cnt_b}, 32'd3);
    check("t4_sat_b_end", {31'b0, sat_b}, 32'd1);
    check("t4_cnt_a_end", {24'b0, cnt_a}, 32'd4);

    // 5: cfg_load wins over a matching bit
    load(4'b1011, 1'b1);
    send_stream(16'b101, 16'b000, 3, "t5_pre");
    @(posedge CLK);
    #1;
    x = 1'b1;
    x_valid = 1'b1;
    cfg_load = 1'b1;
    cfg_pattern = 4'b0110;
    cfg_overlap = 1'b1;
    @(negedge CLK);
    check("t5_y_load", {31'b0, y_a}, 32'd0);
    idle(1);
    @(negedge CLK);
    check("t5_cnt", {24'b0, cnt_a}, 32'd0);
    send_stream(16'b0110, 16'b0001, 4, "t5_new");

    // 6: reset mid-stream discards history and restores defaults
    load(4'b1011, 1'b1);
    send_stream(16'b101, 16'b000, 3, "t6_pre");
    @(posedge CLK);
    #1;
    RST = 1'b1;
    x_valid = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    send_stream(16'b11011, 16'b00001, 5, "t6_post");
    idle(1);
    @(negedge CLK);
    check("t6_cnt", {24'b0, cnt_a}, 32'd1);

    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
